pio_wb_arbiter: RTL and testbench

Two-master Wishbone classic arbiter that shares the PIO block's single Wishbone slave port. Master 0 is the management core's user-project Wishbone bus. Master 1 is a user-side master, such as a DMA or FIFO refill engine. The arbiter sits in the user project wrapper, between both masters and the PIO slave. It applies round-robin grant, holds the grant for the whole bus cycle, and terminates a cycle with an error response if the slave does not acknowledge within a fixed number of cycles.

---
 rtl/pio_wb_pkg.sv | 16 +
 rtl/pio_wb_timeout.sv | 37 +++
 rtl/pio_wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_pio_wb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_wb_pkg.sv
// Shared types and constants for the PIO Wishbone arbiter and future masters on the same port.
package pio_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Index of a Wishbone master on the shared PIO port
    typedef logic gnt_idx_t;

endpackage

// File: rtl/pio_wb_timeout.sv
// Saturating count of cycles a strobe has waited for an ack; expired once the count hits TIMEOUT.
module pio_wb_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb_i,
    input  logic ack_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !stb_i || ack_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/pio_wb_arbiter.sv
// Round-robin two-master Wishbone classic arbiter for the PIO slave port, with ack timeout.
module pio_wb_arbiter
    import pio_wb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    localparam int unsigned SEL_W  = DATA_W / 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o
);

    arb_state_e state_q, state_d;
    gnt_idx_t   last_q, last_d;
    gnt_idx_t   owner_q, owner_d;
    logic       expired;
    logic       timeout_hit;
    logic       cnt_clr;

    assign cnt_clr = (state_q != GNT0) && (state_q != GNT1);

    pio_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .stb_i     (s_stb_o),
        .ack_i     (s_ack_i),
        .clr_i     (cnt_clr),
        .expired_o (expired)
    );

    // Next-state and bus muxing; an ack on the expiry cycle beats the timeout
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        timeout_hit = 1'b0;
        s_cyc_o     = 1'b0;
        s_stb_o     = 1'b0;
        s_we_o      = 1'b0;
        s_sel_o     = '0;
        s_adr_o     = '0;
        s_dat_o     = '0;
        m0_dat_o    = '0;
        m0_ack_o    = 1'b0;
        m0_err_o    = 1'b0;
        m1_dat_o    = '0;
        m1_ack_o    = 1'b0;
        m1_err_o    = 1'b0;
        gnt_o       = 2'b00;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                gnt_o       = 2'b01;
                s_cyc_o     = m0_cyc_i;
                s_stb_o     = m0_stb_i;
                s_we_o      = m0_we_i;
                s_sel_o     = m0_sel_i;
                s_adr_o     = m0_adr_i;
                s_dat_o     = m0_dat_i;
                m0_ack_o    = s_ack_i;
                m0_dat_o    = s_dat_i;
                timeout_hit = expired && m0_cyc_i && m0_stb_i && !s_ack_i;
                m0_err_o    = timeout_hit;
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (timeout_hit) begin
                    state_d = ERR;
                    owner_d = 1'b0;
                end
            end
            GNT1: begin
                gnt_o       = 2'b10;
                s_cyc_o     = m1_cyc_i;
                s_stb_o     = m1_stb_i;
                s_we_o      = m1_we_i;
                s_sel_o     = m1_sel_i;
                s_adr_o     = m1_adr_i;
                s_dat_o     = m1_dat_i;
                m1_ack_o    = s_ack_i;
                m1_dat_o    = s_dat_i;
                timeout_hit = expired && m1_cyc_i && m1_stb_i && !s_ack_i;
                m1_err_o    = timeout_hit;
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ERR;
                    owner_d = 1'b1;
                end
            end
            ERR: begin
                if (owner_q ? !m1_cyc_i : !m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_pio_wb_arbiter.sv
// Directed bench for pio_wb_arbiter: cycle vector table plus timeout, race and reset sequences.
module tb_pio_wb_arbiter;

    localparam logic [31:0] A0 = 32'h3000_0004;
    localparam logic [31:0] A1 = 32'h3000_0010;
    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [3:0]  L0 = 4'hF;
    localparam logic [3:0]  L1 = 4'h3;
    localparam int NV = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat;
    logic        s_ack;
    logic [1:0]  gnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        c0, s0, w0, c1, s1, w1, ack;
        logic [31:0] sdat;
        logic [1:0]  gnt;
        logic        scyc, sstb, swe, a0, a1;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    pio_wb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .wb_clk_i (clk),      .wb_rst_ni (rst_n),
        .m0_cyc_i (m0_cyc),   .m0_stb_i  (m0_stb),   .m0_we_i  (m0_we),
        .m0_sel_i (m0_sel),   .m0_adr_i  (m0_adr),   .m0_dat_i (m0_dat),
        .m0_dat_o (m0_dat_o), .m0_ack_o  (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc),   .m1_stb_i  (m1_stb),   .m1_we_i  (m1_we),
        .m1_sel_i (m1_sel),   .m1_adr_i  (m1_adr),   .m1_dat_i (m1_dat),
        .m1_dat_o (m1_dat_o), .m1_ack_o  (m1_ack_o), .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),  .s_stb_o   (s_stb_o),  .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),  .s_adr_o   (s_adr_o),  .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat),    .s_ack_i   (s_ack),    .gnt_o    (gnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t mk(input logic c0, s0, w0, c1, s1, w1, ack, input logic [31:0] sdat,
                                input logic [1:0] gnt, input logic scyc, sstb, swe, a0, a1,
                                input logic [31:0] d0, d1);
        vec_t v;
        v.c0 = c0; v.s0 = s0; v.w0 = w0; v.c1 = c1; v.s1 = s1; v.w1 = w1; v.ack = ack;
        v.sdat = sdat; v.gnt = gnt; v.scyc = scyc; v.sstb = sstb; v.swe = swe;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    task automatic drive(input logic c0, s0, w0, c1, s1, w1, ack, input logic [31:0] sdat);
        m0_cyc = c0; m0_stb = s0; m0_we = w0;
        m1_cyc = c1; m1_stb = s1; m1_we = w1;
        s_ack = ack; s_dat = sdat;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        int          err_cnt, first_err;

        // Tie from reset, alternation, block cycle, single read, stray ack
        vecs[0]  = mk(1,1,0, 1,1,0, 0, 32'h0,         2'b00, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[1]  = mk(1,1,0, 1,1,0, 1, 32'hA5A5_A5A5, 2'b01, 1,1,0, 1,0, 32'hA5A5_A5A5, 32'h0);
        vecs[2]  = mk(0,0,0, 1,1,0, 0, 32'h0,         2'b01, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[3]  = mk(0,0,0, 1,1,0, 0, 32'h0,         2'b00, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[4]  = mk(0,0,0, 1,1,0, 1, 32'h1234_5678, 2'b10, 1,1,0, 0,1, 32'h0, 32'h1234_5678);
        vecs[5]  = mk(0,0,0, 0,0,0, 0, 32'h0,         2'b10, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[6]  = mk(1,1,0, 1,1,0, 0, 32'h0,         2'b00, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[7]  = mk(1,1,0, 1,1,0, 1, 32'h0BAD_F00D, 2'b01, 1,1,0, 1,0, 32'h0BAD_F00D, 32'h0);
        vecs[8]  = mk(0,0,0, 1,1,0, 0, 32'h0,         2'b01, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[9]  = mk(0,0,0, 1,1,0, 0, 32'h0,         2'b00, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[10] = mk(1,1,0, 1,1,1, 1, 32'h0,         2'b10, 1,1,1, 0,1, 32'h0, 32'h0);
        vecs[11] = mk(1,1,0, 1,0,1, 0, 32'h0,         2'b10, 1,0,1, 0,0, 32'h0, 32'h0);
        vecs[12] = mk(1,1,0, 1,1,1, 1, 32'h0,         2'b10, 1,1,1, 0,1, 32'h0, 32'h0);
        vecs[13] = mk(1,1,0, 1,1,1, 1, 32'h0,         2'b10, 1,1,1, 0,1, 32'h0, 32'h0);
        vecs[14] = mk(1,1,0, 1,1,1, 1, 32'h0,         2'b10, 1,1,1, 0,1, 32'h0, 32'h0);
        vecs[15] = mk(1,1,0, 0,0,0, 0, 32'h0,         2'b10, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[16] = mk(1,1,0, 0,0,0, 0, 32'h0,         2'b00, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[17] = mk(1,1,0, 0,0,0, 1, 32'hDEAD_BEEF, 2'b01, 1,1,0, 1,0, 32'hDEAD_BEEF, 32'h0);
        vecs[18] = mk(0,0,0, 0,0,0, 0, 32'h0,         2'b01, 0,0,0, 0,0, 32'h0, 32'h0);
        vecs[19] = mk(0,0,0, 0,0,0, 1, 32'hFFFF_FFFF, 2'b00, 0,0,0, 0,0, 32'h0, 32'h0);

        rst_n = 1'b0;
        m0_sel = L0; m0_adr = A0; m0_dat = D0;
        m1_sel = L1; m1_adr = A1; m1_dat = D1;
        drive(0,0,0, 0,0,0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        chk("reset.gnt", 32'(gnt_o), 32'h0);
        chk("reset.s_cyc", 32'(s_cyc_o), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            drive(v.c0, v.s0, v.w0, v.c1, v.s1, v.w1, v.ack, v.sdat);
            #1;
            e_adr = (v.gnt == 2'b01) ? A0 : (v.gnt == 2'b10) ? A1 : 32'h0;
            e_dat = (v.gnt == 2'b01) ? D0 : (v.gnt == 2'b10) ? D1 : 32'h0;
            e_sel = (v.gnt == 2'b01) ? L0 : (v.gnt == 2'b10) ? L1 : 4'h0;
            chk($sformatf("v%0d.gnt", i),    32'(gnt_o),    32'(v.gnt));
            chk($sformatf("v%0d.s_cyc", i),  32'(s_cyc_o),  32'(v.scyc));
            chk($sformatf("v%0d.s_stb", i),  32'(s_stb_o),  32'(v.sstb));
            chk($sformatf("v%0d.s_we", i),   32'(s_we_o),   32'(v.swe));
            chk($sformatf("v%0d.s_adr", i),  s_adr_o,       e_adr);
            chk($sformatf("v%0d.s_dat", i),  s_dat_o,       e_dat);
            chk($sformatf("v%0d.s_sel", i),  32'(s_sel_o),  32'(e_sel));
            chk($sformatf("v%0d.m0_ack", i), 32'(m0_ack_o), 32'(v.a0));
            chk($sformatf("v%0d.m1_ack", i), 32'(m1_ack_o), 32'(v.a1));
            chk($sformatf("v%0d.m0_dat", i), m0_dat_o,      v.d0);
            chk($sformatf("v%0d.m1_dat", i), m1_dat_o,      v.d1);
            chk($sformatf("v%0d.m0_err", i), 32'(m0_err_o), 32'h0);
            chk($sformatf("v%0d.m1_err", i), 32'(m1_err_o), 32'h0);
            next_cycle();
        end

        // Timeout: slave never acks m0; m1 waits and is served after m0 leaves ERR
        drive(1,1,0, 0,0,0, 0, 32'h0);
        next_cycle();
        drive(1,1,0, 1,1,0, 0, 32'h0);
        err_cnt = 0;
        first_err = -1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (m0_err_o) begin
                err_cnt++;
                if (first_err < 0) first_err = i;
            end
            if (i == 10) begin
                chk("to.err_state.s_cyc", 32'(s_cyc_o), 32'h0);
                chk("to.err_state.m0_ack", 32'(m0_ack_o), 32'h0);
            end
            next_cycle();
        end
        chk("to.err_pulses", 32'(err_cnt), 32'd1);
        chk("to.err_cycle", 32'(first_err), 32'd8);
        drive(0,0,0, 1,1,0, 0, 32'h0);
        next_cycle();
        #1;
        chk("to.idle_gnt", 32'(gnt_o), 32'h0);
        next_cycle();
        #1;
        chk("to.m1_gnt", 32'(gnt_o), 32'h2);
        chk("to.m1_err", 32'(m1_err_o), 32'h0);
        drive(0,0,0, 0,0,0, 0, 32'h0);
        next_cycle();
        next_cycle();

        // Ack lands on the cycle the count reaches TIMEOUT
        drive(1,1,0, 0,0,0, 0, 32'h0);
        next_cycle();
        err_cnt = 0;
        for (int i = 0; i <= 8; i++) begin
            if (i == 8) begin
                s_ack = 1'b1;
                s_dat = 32'hCAFE_F00D;
            end
            #1;
            if (m0_err_o) err_cnt++;
            if (i == 8) begin
                chk("race.m0_ack", 32'(m0_ack_o), 32'h1);
                chk("race.m0_dat", m0_dat_o, 32'hCAFE_F00D);
            end
            next_cycle();
        end
        chk("race.err_pulses", 32'(err_cnt), 32'd0);
        s_ack = 1'b0;
        s_dat = 32'h0;
        #1;
        chk("race.gnt_after", 32'(gnt_o), 32'h1);
        chk("race.err_after", 32'(m0_err_o), 32'h0);
        drive(0,0,0, 0,0,0, 0, 32'h0);
        next_cycle();
        next_cycle();

        // Reset asserted while m1 owns the bus with a strobe outstanding
        drive(0,0,0, 1,1,1, 0, 32'h0);
        next_cycle();
        #1;
        chk("rst.pre_gnt", 32'(gnt_o), 32'h2);
        chk("rst.pre_s_cyc", 32'(s_cyc_o), 32'h1);
        s_ack = 1'b1;
        s_dat = 32'h55AA_55AA;
        rst_n = 1'b0;
        #1;
        chk("rst.gnt", 32'(gnt_o), 32'h0);
        chk("rst.s_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst.s_stb", 32'(s_stb_o), 32'h0);
        chk("rst.s_we", 32'(s_we_o), 32'h0);
        chk("rst.s_adr", s_adr_o, 32'h0);
        chk("rst.s_dat", s_dat_o, 32'h0);
        chk("rst.m1_ack", 32'(m1_ack_o), 32'h0);
        chk("rst.m1_dat", m1_dat_o, 32'h0);
        chk("rst.m1_err", 32'(m1_err_o), 32'h0);
        rst_n = 1'b1;
        drive(1,1,0, 0,0,0, 0, 32'h0);
        #1;
        chk("rst.release_idle", 32'(gnt_o), 32'h0);
        next_cycle();
        #1;
        chk("rst.m0_gnt", 32'(gnt_o), 32'h1);
        chk("rst.m0_s_cyc", 32'(s_cyc_o), 32'h1);
        drive(0,0,0, 0,0,0, 0, 32'h0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
